bcd_seq_conv: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Replaces the single-cycle combinational 8-bit converter between switch/counter sources and display drivers.
- Start/busy/done handshake. Scales to any input width without a long combinational chain.
- Optional multiplexed 7-segment driver.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_seq_conv_if.sv | 15 +
 rtl/bcd_dabble_digit.sv | 16 +
 rtl/bcd_seq_conv.sv | 152 +++++++++++++++
 tb/tb_bcd_seq_conv.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   // Converter FSM states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Ceiling log2, never below 1 so that counters always have at least one bit
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return (r == 0) ? 1 : r;
   endfunction

   // Decimal digits needed to show 2^bin_w - 1: ceil(bin_w * log10(2))
   function automatic int unsigned digits_needed(input int unsigned bin_w);
      return (bin_w * 30103 + 99999) / 100000;
   endfunction

   // Active-low segments, bit 0 = a ... bit 6 = g; codes 10..15 blank
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
   };

   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Start/busy/done handshake and result bus of the BCD converter.
interface bcd_seq_conv_if #(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  overflow;

   modport master (output start, bin_in, input busy, done, bcd_out, overflow);
   modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bcd_dabble_digit.sv
// One BCD digit of the double-dabble datapath: correct by +3, then shift left one bit.
module bcd_dabble_digit (
   input  logic [3:0] digit_i,
   input  logic       shift_i,
   output logic [3:0] digit_o,
   output logic       shift_o
);
   logic [3:0] corr;

   // Add-3 correction (4-bit, no inter-digit carry) followed by the shift
   always_comb begin
      corr    = (digit_i > 4'd4) ? digit_i + 4'd3 : digit_i;
      shift_o = corr[3];
      digit_o = {corr[2:0], shift_i};
   end
endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter, one bit per clock (double dabble).
// Optional multiplexed 7-segment driver enabled by BCD_SEQ_CONV_SEG7_EN.
module bcd_seq_conv
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W       = 8,
   parameter int unsigned DIGITS      = 3
`ifdef BCD_SEQ_CONV_SEG7_EN
   ,
   parameter int unsigned REFRESH_DIV = 100000
`endif
) (
   input  logic              clk,
   input  logic              rst,
   bcd_seq_conv_if.slave     bus
`ifdef BCD_SEQ_CONV_SEG7_EN
   ,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
`endif
);
   localparam int unsigned CNT_W = clog2(BIN_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_e              state_q, state_d;
   logic [BIN_W-1:0]    shreg_q, shreg_d;
   logic [4*DIGITS-1:0] scratch_q, scratch_d, scratch_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sticky_q, sticky_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic [DIGITS:0]     chain;

   // The shift register MSB feeds digit 0; chain[DIGITS] is the bit lost off the top
   assign chain[0] = shreg_q[BIN_W-1];

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_dabble_digit u_digit (
         .digit_i (scratch_q[4*g +: 4]),
         .shift_i (chain[g]),
         .digit_o (scratch_nxt[4*g +: 4]),
         .shift_o (chain[g+1])
      );
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      sticky_d  = sticky_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               shreg_d   = bus.bin_in;
               scratch_d = '0;
               sticky_d  = 1'b0;
               cnt_d     = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
            scratch_d = scratch_nxt;
            sticky_d  = sticky_q | chain[DIGITS];
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               // Result only becomes visible on the completing edge
               bcd_d   = scratch_nxt;
               ovf_d   = sticky_q | chain[DIGITS];
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StDone);
   assign bus.bcd_out  = bcd_q;
   assign bus.overflow = ovf_q;

`ifdef BCD_SEQ_CONV_SEG7_EN
   localparam int unsigned REF_W = clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = clog2(DIGITS);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [REF_W-1:0]  refresh_q, refresh_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic [3:0]        digit;

   // Scan registers; outputs are registered so they come out of reset dark
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_q <= '0;
         idx_q     <= '0;
         an_q      <= '1;
         seg_q     <= '1;
      end else begin
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   // Refresh divider, digit rotation and segment decode of the selected digit
   always_comb begin
      refresh_d = refresh_q + REF_W'(1);
      idx_d     = idx_q;
      if (refresh_q == REF_LAST) begin
         refresh_d = '0;
         idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      an_d        = '1;
      an_d[idx_q] = 1'b0;
      digit       = bcd_q[int'(idx_q)*4 +: 4];
      seg_d       = ovf_q ? SEG_DASH : SEG_LUT[digit];
   end

   assign seg = seg_q;
   assign an  = an_q;
`endif
endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed bench for bcd_seq_conv: four instances with different widths.
module tb_bcd_seq_conv;
   logic clk, rst;
   int   n_vec, n_err;

   logic [3:0]  start_v;
   logic [31:0] bin_v [4];
   logic [3:0]  busy_v, done_v, ovf_v;
   logic [31:0] bcd_v [4];

   bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(3)) if8  ();
   bcd_seq_conv_if #(.BIN_W(8),  .DIGITS(2)) if2  ();
   bcd_seq_conv_if #(.BIN_W(16), .DIGITS(5)) if16 ();
   bcd_seq_conv_if #(.BIN_W(10), .DIGITS(3)) if10 ();

   assign if8.start  = start_v[0];  assign if8.bin_in  = bin_v[0][7:0];
   assign if2.start  = start_v[1];  assign if2.bin_in  = bin_v[1][7:0];
   assign if16.start = start_v[2];  assign if16.bin_in = bin_v[2][15:0];
   assign if10.start = start_v[3];  assign if10.bin_in = bin_v[3][9:0];
   assign busy_v = {if10.busy, if16.busy, if2.busy, if8.busy};
   assign done_v = {if10.done, if16.done, if2.done, if8.done};
   assign ovf_v  = {if10.overflow, if16.overflow, if2.overflow, if8.overflow};
   assign bcd_v[0] = {20'd0, if8.bcd_out};
   assign bcd_v[1] = {24'd0, if2.bcd_out};
   assign bcd_v[2] = {12'd0, if16.bcd_out};
   assign bcd_v[3] = {20'd0, if10.bcd_out};

`ifdef BCD_SEQ_CONV_SEG7_EN
   logic [6:0] seg8, seg2, seg16, seg10;
   logic [2:0] an8, an10;
   logic [1:0] an2;
   logic [4:0] an16;
   bcd_seq_conv #(.BIN_W(8), .DIGITS(3), .REFRESH_DIV(4)) u_dut8 (
      .clk(clk), .rst(rst), .bus(if8), .seg(seg8), .an(an8));
   bcd_seq_conv #(.BIN_W(8), .DIGITS(2), .REFRESH_DIV(4)) u_dut2 (
      .clk(clk), .rst(rst), .bus(if2), .seg(seg2), .an(an2));
   bcd_seq_conv #(.BIN_W(16), .DIGITS(5), .REFRESH_DIV(4)) u_dut16 (
      .clk(clk), .rst(rst), .bus(if16), .seg(seg16), .an(an16));
   bcd_seq_conv #(.BIN_W(10), .DIGITS(3), .REFRESH_DIV(4)) u_dut10 (
      .clk(clk), .rst(rst), .bus(if10), .seg(seg10), .an(an10));
`else
   bcd_seq_conv #(.BIN_W(8),  .DIGITS(3)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
   bcd_seq_conv #(.BIN_W(8),  .DIGITS(2)) u_dut2  (.clk(clk), .rst(rst), .bus(if2));
   bcd_seq_conv #(.BIN_W(16), .DIGITS(5)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
   bcd_seq_conv #(.BIN_W(10), .DIGITS(3)) u_dut10 (.clk(clk), .rst(rst), .bus(if10));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One conversion on instance d; checks latency, busy length, single done pulse, result
   task automatic run(input int d, input logic [31:0] bin, input logic [31:0] exp,
                      input logic ovf, input int bw);
      int lat, nbusy;
      bit seen;
      bin_v[d]   = bin;
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      bin_v[d]   = '1;
      lat = 0; nbusy = 0; seen = 0;
      while (!seen && lat < bw + 10) begin
         if (busy_v[d]) nbusy++;
         if (done_v[d]) seen = 1;
         else begin
            tick();
            lat++;
         end
      end
      check_eq($sformatf("lat%0d_%0d", d, bin), lat, bw);
      check_eq($sformatf("bcd%0d_%0d", d, bin), bcd_v[d], exp);
      check_eq($sformatf("ovf%0d_%0d", d, bin), {31'd0, ovf_v[d]}, {31'd0, ovf});
      tick();
      check_eq($sformatf("pulse%0d_%0d", d, bin), {31'd0, done_v[d]}, 32'd0);
      check_eq($sformatf("idle%0d_%0d", d, bin), {31'd0, busy_v[d]}, 32'd0);
      check_eq($sformatf("nbusy%0d_%0d", d, bin), nbusy, bw + 1);
   endtask

   initial begin
      int n, ndone;
      n_vec = 0; n_err = 0;
      rst = 1'b1; start_v = '0;
      for (int i = 0; i < 4; i++) bin_v[i] = '0;
      tick(); tick();
      check_eq("rst_busy", {28'd0, busy_v}, 32'd0);
      check_eq("rst_done", {28'd0, done_v}, 32'd0);
      check_eq("rst_ovf",  {28'd0, ovf_v},  32'd0);
      check_eq("rst_bcd",  bcd_v[0], 32'd0);
`ifdef BCD_SEQ_CONV_SEG7_EN
      check_eq("rst_an",  {29'd0, an8},  32'h7);
      check_eq("rst_seg", {25'd0, seg8}, 32'h7F);
`endif
      rst = 1'b0;
      tick();

      run(0, 32'd255, 32'h255, 1'b0, 8);

      // Back to back with start held: 0 then 99
      bin_v[0] = 32'd0; start_v[0] = 1'b1;
      tick();
      bin_v[0] = 32'd99;
      n = 0;
      while (!done_v[0] && n < 30) begin tick(); n++; end
      check_eq("b2b_lat0", n, 8);
      check_eq("b2b_bcd0", bcd_v[0], 32'h000);
      tick(); n = 1;
      while (!done_v[0] && n < 30) begin tick(); n++; end
      check_eq("b2b_lat1", n, 10);
      check_eq("b2b_bcd1", bcd_v[0], 32'h099);
      start_v[0] = 1'b0;
      tick();
      check_eq("b2b_idle", {31'd0, busy_v[0]}, 32'd0);
      tick();
      check_eq("b2b_hold", bcd_v[0], 32'h099);

      // Reset three cycles into a conversion
      bin_v[0] = 32'd128; start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("abort_busy", {31'd0, busy_v[0]}, 32'd0);
      check_eq("abort_bcd",  bcd_v[0], 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done_v[0]) ndone++;
         tick();
      end
      check_eq("abort_nodone", ndone, 0);
      run(0, 32'd128, 32'h128, 1'b0, 8);

      // Two-digit instance: overflow then a clean result
      run(1, 32'd200, 32'h00, 1'b1, 8);
`ifdef BCD_SEQ_CONV_SEG7_EN
      tick(); tick();
      check_eq("dash_seg", {25'd0, seg2}, 32'h3F);
`endif
      run(1, 32'd42, 32'h42, 1'b0, 8);
      run(1, 32'd99, 32'h99, 1'b0, 8);

      run(2, 32'd65535, 32'h65535, 1'b0, 16);
      run(2, 32'd10000, 32'h10000, 1'b0, 16);

      run(3, 32'd305, 32'h305, 1'b0, 10);
      run(3, 32'd1023, 32'h023, 1'b1, 10);
      run(3, 32'd305, 32'h305, 1'b0, 10);

`ifdef BCD_SEQ_CONV_SEG7_EN
      begin
         logic [2:0] an_exp  [3];
         logic [6:0] seg_exp [3];
         an_exp  = '{3'b110, 3'b101, 3'b011};
         seg_exp = '{7'b0010010, 7'b1000000, 7'b0110000};
         n = 0;
         while (an10 != 3'b110 && n < 20) begin tick(); n++; end
         check_eq("scan_sync", {29'd0, an10}, 32'h6);
         while (an10 == 3'b110 && n < 40) begin tick(); n++; end
         while (an10 != 3'b110 && n < 60) begin tick(); n++; end
         for (int s = 0; s < 4; s++) begin
            check_eq($sformatf("scan_an%0d", s),  {29'd0, an10},  {29'd0, an_exp[s % 3]});
            check_eq($sformatf("scan_seg%0d", s), {25'd0, seg10}, {25'd0, seg_exp[s % 3]});
            tick(); tick(); tick();
            check_eq($sformatf("scan_hold%0d", s), {29'd0, an10}, {29'd0, an_exp[s % 3]});
            tick();
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
